// File: rtl/sample_player_pkg.sv
// Shared types and constants for the sample player and its DAC serializer.
package sample_player_pkg;

  localparam int SAMPLE_W = 12;
  localparam int FRAME_W  = 16;
  localparam int WORD_W   = 2 * SAMPLE_W;

  localparam logic [3:0] DAC_CFG_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

  function automatic logic [FRAME_W-1:0] build_frame(input logic [3:0]          cfg,
                                                      input logic [SAMPLE_W-1:0] sample);
    return {cfg, sample};
  endfunction

endpackage

// File: rtl/sample_player_if.sv
// Read handshake between the sample player and the upstream packed-sample buffer.
interface sample_player_if;
  import sample_player_pkg::*;

  logic              rd;
  logic [WORD_W-1:0] data_in;
  logic              outbyte;

  modport master (output rd, input data_in, input outbyte);
  modport slave  (input rd, output data_in, output outbyte);

endinterface

// File: rtl/sample_player_dac_spi_tx.sv
// 16-bit MSB-first serializer for the DAC: cs_n low for 32 SCK half-periods,
// sck idles low, mosi moves on the falling edge.
module dac_spi_tx
  import sample_player_pkg::*;
#(
  parameter int SCK_DIV = 4
) (
  input  logic               i_clk,
  input  logic               i_resetn,
  input  logic               i_start,
  input  logic [FRAME_W-1:0] i_word,
  output logic               o_cs_n,
  output logic               o_sck,
  output logic               o_mosi,
  output logic               o_busy
);

  localparam int DIV_W = $clog2(SCK_DIV) + 1;

  logic [DIV_W-1:0]   r_div;
  logic [4:0]         r_half;
  logic [FRAME_W-1:0] r_shift;
  logic               r_cs_n;
  logic               r_sck;
  logic               r_mosi;
  logic               r_busy;
  logic               w_half_end;

  assign w_half_end = (r_div == DIV_W'(SCK_DIV - 1));

  // Frame sequencer: even half-periods hold sck low, odd ones high; shift on the fall.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_div   <= '0;
      r_half  <= 5'd0;
      r_shift <= '0;
      r_cs_n  <= 1'b1;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_busy  <= 1'b0;
    end else if (!r_busy) begin
      r_div  <= '0;
      r_half <= 5'd0;
      r_sck  <= 1'b0;
      if (i_start) begin
        r_busy  <= 1'b1;
        r_cs_n  <= 1'b0;
        r_shift <= i_word;
        r_mosi  <= i_word[FRAME_W-1];
      end else begin
        r_busy <= 1'b0;
        r_cs_n <= 1'b1;
        r_mosi <= 1'b0;
      end
    end else if (w_half_end) begin
      r_div <= '0;
      if (r_half == 5'd31) begin
        r_busy <= 1'b0;
        r_cs_n <= 1'b1;
        r_sck  <= 1'b0;
        r_mosi <= 1'b0;
      end else begin
        r_half <= r_half + 5'd1;
        r_sck  <= ~r_sck;
        if (r_sck) begin
          r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
          r_mosi  <= r_shift[FRAME_W-2];
        end else begin
          r_shift <= r_shift;
        end
      end
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign o_cs_n = r_cs_n;
  assign o_sck  = r_sck;
  assign o_mosi = r_mosi;
  assign o_busy = r_busy;

endmodule

// File: rtl/sample_player.sv
// Plays packed 12-bit sample pairs from an upstream buffer to a serial DAC at a
// fixed sample rate, fetching a new word whenever both slots have been played.
module sample_player
  import sample_player_pkg::*;
#(
  parameter int         CLK_DIV    = 2268,
  parameter int         SCK_DIV    = 4,
  parameter logic [3:0] DAC_CFG    = DAC_CFG_DEFAULT,
  parameter int         RD_TIMEOUT = 4
) (
  input  logic                i_clk,
  input  logic                i_resetn,
  input  logic                i_en,
  sample_player_if.master     buf_if,
  output logic                o_dac_cs_n,
  output logic                o_dac_sck,
  output logic                o_dac_mosi,
  output logic [SAMPLE_W-1:0] o_sample_out,
  output logic                o_sample_valid,
  output logic                o_underrun,
  output logic                o_busy
);

  localparam int CNT_W  = $clog2(CLK_DIV);
  localparam int WAIT_W = $clog2(RD_TIMEOUT) + 1;

  fetch_state_e        r_state;
  fetch_state_e        w_next_state;
  logic [CNT_W-1:0]    r_rate_cnt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [WORD_W-1:0]   r_word;
  logic [1:0]          r_remaining;
  logic [SAMPLE_W-1:0] r_sample_out;
  logic                r_rd;
  logic                r_sample_valid;
  logic                r_underrun;
  logic [SAMPLE_W-1:0] w_next_sample;
  logic [SAMPLE_W-1:0] w_frame_sample;
  logic [FRAME_W-1:0]  w_frame_word;
  logic                w_tick;
  logic                w_load;
  logic                w_has_sample;

  assign w_tick       = i_en && (r_rate_cnt == CNT_W'(CLK_DIV - 1));
  assign w_has_sample = (r_remaining != 2'd0);

  // Sample-rate counter; disabling playback holds it at zero.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_rate_cnt <= '0;
    end else if (!i_en || w_tick) begin
      r_rate_cnt <= '0;
    end else begin
      r_rate_cnt <= r_rate_cnt + CNT_W'(1);
    end
  end

  // Fetch FSM next state; a timed-out read returns to IDLE without loading.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_en && !w_has_sample) w_next_state = ST_REQ;
        else                       w_next_state = ST_IDLE;
      end
      ST_REQ: begin
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (buf_if.outbyte) begin
          w_next_state = ST_IDLE;
          w_load       = 1'b1;
        end else if (r_wait_cnt == WAIT_W'(RD_TIMEOUT - 1)) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Fetch FSM state, read strobe and WAIT timeout counter.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state    <= ST_IDLE;
      r_rd       <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      r_rd    <= (w_next_state == ST_REQ);
      if (r_state == ST_WAIT) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      else                    r_wait_cnt <= '0;
    end
  end

  // Slot selection: low half plays first; an underrun re-sends the last sample.
  always_comb begin
    w_next_sample  = r_word[SAMPLE_W-1:0];
    w_frame_sample = r_sample_out;
    if (r_remaining == 2'd1) w_next_sample = r_word[WORD_W-1:SAMPLE_W];
    else                     w_next_sample = r_word[SAMPLE_W-1:0];
    if (w_tick && w_has_sample) w_frame_sample = w_next_sample;
    else                        w_frame_sample = r_sample_out;
  end

  assign w_frame_word = build_frame(DAC_CFG, w_frame_sample);

  // Slot buffer and sample outputs. A load only happens with no slots left, so
  // it never competes with a decrement; a coinciding tick still sees the old count.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_word         <= '0;
      r_remaining    <= 2'd0;
      r_sample_out   <= '0;
      r_sample_valid <= 1'b0;
      r_underrun     <= 1'b0;
    end else begin
      r_sample_valid <= w_tick && w_has_sample;
      r_underrun     <= w_tick && !w_has_sample;
      if (w_load) begin
        r_word      <= buf_if.data_in;
        r_remaining <= 2'd2;
      end else if (w_tick && w_has_sample) begin
        r_remaining <= r_remaining - 2'd1;
      end else begin
        r_remaining <= r_remaining;
      end
      if (w_tick && w_has_sample) r_sample_out <= w_next_sample;
      else                        r_sample_out <= r_sample_out;
    end
  end

  dac_spi_tx #(
    .SCK_DIV (SCK_DIV)
  ) u_spi (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .i_start  (w_tick),
    .i_word   (w_frame_word),
    .o_cs_n   (o_dac_cs_n),
    .o_sck    (o_dac_sck),
    .o_mosi   (o_dac_mosi),
    .o_busy   (o_busy)
  );

  assign buf_if.rd      = r_rd;
  assign o_sample_out   = r_sample_out;
  assign o_sample_valid = r_sample_valid;
  assign o_underrun     = r_underrun;

endmodule

// File: tb/tb_sample_player.sv
// Directed bench for sample_player: CLK_DIV=100, SCK_DIV=2, RD_TIMEOUT=4.
module tb_sample_player;
  import sample_player_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic        cs_n, sck, mosi, sample_valid, underrun, busy;
  logic [11:0] sample_out;

  sample_player_if buf_bus ();

  sample_player #(
    .CLK_DIV    (100),
    .SCK_DIV    (2),
    .DAC_CFG    (4'b0011),
    .RD_TIMEOUT (4)
  ) dut (
    .i_clk          (clk),
    .i_resetn       (resetn),
    .i_en           (en),
    .buf_if         (buf_bus),
    .o_dac_cs_n     (cs_n),
    .o_dac_sck      (sck),
    .o_dac_mosi     (mosi),
    .o_sample_out   (sample_out),
    .o_sample_valid (sample_valid),
    .o_underrun     (underrun),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observation state, owned by the monitor process.
  int          cyc = 0;
  int          rd_cnt = 0, sv_cnt = 0, ur_cnt = 0;
  int          busy_bad = 0, rd_consec = 0;
  int          cur_edges = 0, cs_low = 0;
  logic        prev_rd = 1'b0, prev_cs = 1'b1, prev_sck = 1'b0;
  logic [15:0] shreg = 16'h0000;
  logic [15:0] frames[$];
  int          frame_edges[$];
  int          frame_len[$];
  int          rd_cyc[$];
  int          rd_at_valid[$];

  // Upstream responder controls, written by the main sequence.
  logic        resp_on = 1'b0;
  logic        ob_manual = 1'b0;
  logic [23:0] resp_data = 24'h000000;
  logic        ob_pending = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int k = 0;
    while (frames.size() < n && k < budget) begin
      step();
      k++;
    end
    check(tag, frames.size(), n);
  endtask

  task automatic wait_edges(input int n, input int budget, input string tag);
    int k = 0;
    while (cur_edges < n && k < budget) begin
      step();
      k++;
    end
    check(tag, cur_edges, n);
  endtask

  task automatic do_reset(input int n);
    resetn    = 1'b0;
    en        = 1'b0;
    resp_on   = 1'b0;
    ob_manual = 1'b0;
    repeat (n) step();
    resetn = 1'b1;
    step();
  endtask

  // Upstream buffer model: outbyte one cycle after an observed rd, or on request.
  initial begin
    buf_bus.outbyte = 1'b0;
    buf_bus.data_in = 24'h000000;
    forever begin
      @(negedge clk);
      buf_bus.outbyte = ob_manual | ob_pending;
      buf_bus.data_in = resp_data;
      ob_pending      = resp_on & (buf_bus.rd === 1'b1);
    end
  end

  // Monitor: counts pulses and reassembles DAC frames from sck rising edges.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (resetn !== 1'b1) begin
        rd_cnt = 0; sv_cnt = 0; ur_cnt = 0; cur_edges = 0; cs_low = 0;
        shreg = 16'h0000; prev_rd = 1'b0; prev_cs = 1'b1; prev_sck = 1'b0;
        frames.delete(); frame_edges.delete(); frame_len.delete();
        rd_cyc.delete(); rd_at_valid.delete();
      end else begin
        if (buf_bus.rd === 1'b1) begin
          rd_cnt++;
          rd_cyc.push_back(cyc);
          if (prev_rd) rd_consec++;
        end
        prev_rd = (buf_bus.rd === 1'b1);
        if (sample_valid === 1'b1) begin
          sv_cnt++;
          rd_at_valid.push_back(rd_cnt);
        end
        if (underrun === 1'b1) ur_cnt++;
        if (busy !== ~cs_n) busy_bad++;
        if (cs_n === 1'b0) begin
          cs_low++;
          if (sck === 1'b1 && prev_sck === 1'b0) begin
            shreg = {shreg[14:0], mosi};
            cur_edges++;
          end
        end
        if (cs_n === 1'b1 && prev_cs === 1'b0) begin
          frames.push_back(shreg);
          frame_edges.push_back(cur_edges);
          frame_len.push_back(cs_low);
          cur_edges = 0;
          cs_low    = 0;
          shreg     = 16'h0000;
        end
        prev_cs  = cs_n;
        prev_sck = sck;
      end
    end
  end

  initial begin
    int n;

    // Reset values while resetn is held low.
    resetn = 1'b0;
    en     = 1'b0;
    repeat (3) step();
    check("rst_rd", buf_bus.rd, 1'b0);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_sck", sck, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_sample_out", sample_out, 12'h000);
    check("rst_sample_valid", sample_valid, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    resetn = 1'b1;
    step();

    // Normal playback of one packed word per two ticks.
    resp_data = 24'hABC123;
    resp_on   = 1'b1;
    en        = 1'b1;
    wait_frames(2, 300, "play_two_frames");
    check("play_frame0", frames[0], 16'h3123);
    check("play_frame1", frames[1], 16'h3ABC);
    check("play_edges0", frame_edges[0], 16);
    check("play_edges1", frame_edges[1], 16);
    check("play_cs_low_len", frame_len[0], 64);
    check("play_valid_cnt", sv_cnt, 2);
    check("play_underrun_cnt", ur_cnt, 0);
    check("play_sample_out", sample_out, 12'hABC);
    wait_frames(4, 250, "play_four_frames");
    check("play_frame2", frames[2], 16'h3123);
    check("play_frame3", frames[3], 16'h3ABC);
    check("play_valid_cnt4", sv_cnt, 4);
    check("play_rd_at_tick1", rd_at_valid[0], 1);
    check("play_rd_at_tick4", rd_at_valid[3], 2);

    // Upstream never answers: timeout retries and an underrun frame.
    do_reset(2);
    en = 1'b1;
    wait_frames(1, 200, "starve_frame");
    check("starve_frame0", frames[0], 16'h3000);
    check("starve_rd_gap", rd_cyc[1] - rd_cyc[0], 6);
    check("starve_underrun_cnt", ur_cnt, 1);
    check("starve_valid_cnt", sv_cnt, 0);
    check("starve_sample_out", sample_out, 12'h000);

    // outbyte lands on the tick cycle: underrun first, word serves the next two ticks.
    do_reset(2);
    resp_data = 24'h456DEF;
    en        = 1'b1;
    repeat (98) step();
    ob_manual = 1'b1;
    step();
    ob_manual = 1'b0;
    wait_frames(3, 400, "coincide_frames");
    check("coincide_frame0", frames[0], 16'h3000);
    check("coincide_frame1", frames[1], 16'h3DEF);
    check("coincide_frame2", frames[2], 16'h3456);
    check("coincide_underrun_cnt", ur_cnt, 1);
    check("coincide_valid_cnt", sv_cnt, 2);

    // One-cycle reset in the middle of a frame.
    do_reset(2);
    resp_data = 24'hABC123;
    resp_on   = 1'b1;
    en        = 1'b1;
    wait_edges(8, 200, "midrst_reach_bit7");
    check("midrst_sample_before", sample_out, 12'h123);
    resetn = 1'b0;
    en     = 1'b0;
    step();
    check("midrst_cs_n", cs_n, 1'b1);
    check("midrst_sample_out", sample_out, 12'h000);
    check("midrst_busy", busy, 1'b0);
    check("midrst_sck", sck, 1'b0);
    resetn = 1'b1;
    repeat (10) step();
    check("midrst_no_rd", rd_cnt, 0);
    en = 1'b1;
    n  = 0;
    while (rd_cnt == 0 && n < 6) begin
      step();
      n++;
    end
    check("midrst_rd_after_en", rd_cnt, 1);
    check("midrst_rd_latency", n, 1);

    // Playback disabled mid-frame: frame completes, buffer retained.
    do_reset(2);
    resp_data = 24'hABC123;
    resp_on   = 1'b1;
    en        = 1'b1;
    wait_edges(8, 200, "endrop_reach_mid");
    en = 1'b0;
    wait_frames(1, 100, "endrop_frame_done");
    check("endrop_frame0", frames[0], 16'h3123);
    check("endrop_edges0", frame_edges[0], 16);
    repeat (300) step();
    check("endrop_no_frames", frames.size(), 1);
    check("endrop_no_rd", rd_cnt, 1);
    check("endrop_valid_cnt", sv_cnt, 1);
    check("endrop_underrun_cnt", ur_cnt, 0);
    en = 1'b1;
    wait_frames(2, 250, "endrop_resume");
    check("endrop_frame1", frames[1], 16'h3ABC);
    check("endrop_rd_at_tick2", rd_at_valid[1], 1);
    check("endrop_resume_underrun", ur_cnt, 0);

    check("rd_never_consecutive", rd_consec, 0);
    check("busy_tracks_cs_n", busy_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_player.md
SAMPLE_PLAYER -- requirements
Module: sample_player

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2268, clk cycles per sample period (44.1 kHz at 100 MHz).
REQ-002 SHALL have parameter SCK_DIV, default 4, clk cycles per DAC SCK half-period.
REQ-003 SHALL have parameter DAC_CFG, default 4'b0011, DAC command nibble prefixed to each frame.
REQ-004 SHALL have parameter RD_TIMEOUT, default 4, cycles to wait for outbyte after rd.
REQ-005 SHALL have one clock and a synchronous, active-low reset: clk input 1 (all logic on posedge) and resetn input 1.
REQ-006 Port en, input, 1: playback enable.
REQ-007 Port rd, output, 1: single-cycle read request to the upstream packed-sample buffer.
REQ-008 Port data_in, input, 24: packed word {sample2[11:0], sample1[11:0]}.
REQ-009 Port outbyte, input, 1: data_in valid strobe.
REQ-010 Port dac_cs_n / dac_sck / dac_mosi, outputs, 1 each: serial DAC bus.
REQ-011 Port sample_out, output, 12: last sample sent.
REQ-012 Port sample_valid, output, 1: one-cycle pulse when sample_out updates.
REQ-013 Port underrun, output, 1: one-cycle pulse on a tick with no buffered sample.
REQ-014 Port busy, output, 1: high while a DAC frame is in flight.

Function
REQ-015 Rate counter SHALL count 0..CLK_DIV-1 while en=1; tick = (count==CLK_DIV-1); en=0 clears count and suppresses ticks.
REQ-016 Slot buffer SHALL hold one word and a remaining count (0..2); sample1 = data_in[11:0] played first, then sample2 = data_in[23:12].
REQ-017 Fetch FSM states: IDLE, REQ, WAIT.
REQ-018 IDLE->REQ when en=1 and remaining==0; REQ drives rd=1 for exactly one cycle and then goes to WAIT.
REQ-019 WAIT->IDLE on outbyte=1, loading data_in and setting remaining=2; WAIT->IDLE without loading after RD_TIMEOUT cycles with no outbyte.
REQ-020 outbyte outside WAIT SHALL be ignored; rd SHALL never be asserted in two consecutive cycles.
REQ-021 On tick with remaining>0: next sample SHALL be latched, remaining decremented, sample_out and sample_valid updated the next cycle, and a DAC frame started.
REQ-022 On tick with remaining==0: underrun SHALL pulse and a frame re-sends the current sample_out; sample_valid SHALL NOT pulse.
REQ-023 Tick and outbyte in the same cycle with remaining==0: tick SHALL be evaluated first (underrun); the loaded word serves later ticks.
REQ-024 DAC frame: 16 bits {DAC_CFG, sample}, MSB first; cs_n low for 32*SCK_DIV cycles starting the cycle after tick; sck idles low; mosi changes while sck low; 16 rising edges per frame; cs_n high at least 1 cycle between frames.
REQ-025 busy=1 from cs_n fall through cs_n rise.
REQ-026 en deasserted mid-frame: the in-flight frame SHALL complete; no new fetch is issued; buffered samples are retained.
REQ-027 Legal configuration requires CLK_DIV > 32*SCK_DIV+2 and SCK_DIV>=1; other values are unsupported.

Reset
REQ-028 resetn=0 SHALL synchronously give: rd=0, dac_cs_n=1, dac_sck=0, dac_mosi=0, sample_out=0, sample_valid=0, underrun=0, busy=0, remaining=0, FSM=IDLE, rate counter=0.
REQ-029 Reset mid-frame SHALL abort the frame immediately, with cs_n=1 the next cycle.

Structure
REQ-030 A shared package SHALL hold the fetch-FSM state enum, the 12-bit sample width, the 16-bit frame width and the DAC_CFG default.
REQ-031 The serializer SHALL be a sub-module dac_spi_tx (start, 16-bit word, SCK_DIV -> cs_n/sck/mosi/busy).

Verification
REQ-032 CLK_DIV=100, SCK_DIV=2, outbyte one cycle after rd with data_in=24'hABC123 -> frames carry 16'h3123 then 16'h3ABC; sample_valid pulses; two rd pulses over four ticks.
REQ-033 Upstream never asserts outbyte -> rd, then idle after 4 cycles; first tick pulses underrun and sends 16'h3000; sample_valid stays 0.
REQ-034 outbyte on the same cycle as a tick with remaining=0 -> underrun pulse; the next two ticks play the loaded word.
REQ-035 resetn=0 for one cycle at mid-frame bit 7 -> cs_n=1 and sample_out=0 next cycle; no rd until en and remaining conditions recur.
REQ-036 en dropped at mid-frame -> exactly 16 sck rising edges complete; no further ticks, rd, or frames; remaining unchanged.
